// File: rtl/clk_period_meter_pkg.sv
// clk_meter_pkg: state encoding and sizing helpers shared by the clock period meter.
package clk_meter_pkg;
    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1023;
    function automatic int tmo_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: request/result bundle between a meter and its controller.
interface clk_period_meter_if #(parameter int CNT_W = 16);
    logic             start;
    logic             clk_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period_sum;
    logic [CNT_W-1:0] high_sum;
    logic             timeout;
    logic             ovf;
    modport master (output start, clk_in, input busy, done, period_sum, high_sum, timeout, ovf);
    modport slave  (input start, clk_in, output busy, done, period_sum, high_sum, timeout, ovf);
endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: brings an asynchronous clock into clk domain and flags its rising edges.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = lvl_o & ~prev_q;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: accumulates period and high time of a divided clock over NUM_PER periods,
// counted in clk cycles, with edge-loss timeout and accumulator saturation reporting.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int NUM_PER     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input logic              clk,
    input logic              rst,
    clk_period_meter_if.slave bus
);
    localparam int               TMO_W = tmo_w(TIMEOUT);
    localparam int               EDG_W = $clog2(NUM_PER + 1);
    localparam logic [CNT_W-1:0] SAT   = CNT_W'(sat_max(CNT_W));

    state_e           state_q, state_d;
    logic [EDG_W-1:0] edges_q, edges_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, psum_q, psum_d, hsum_q, hsum_d;
    logic             sat_q, sat_d, tout_q, tout_d, ovf_q, ovf_d;
    logic             lvl, rise, last, expired, clip;
    logic [CNT_W-1:0] cnt_inc, hcnt_inc;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.clk_in),
        .lvl_o  (lvl),
        .rise_o (rise)
    );

    assign cnt_inc  = (cnt_q == SAT) ? SAT : cnt_q + 1'b1;
    assign hcnt_inc = (hcnt_q == SAT || !lvl) ? hcnt_q : hcnt_q + 1'b1;
    assign clip     = (cnt_q == SAT) || (lvl && hcnt_q == SAT);
    assign last     = rise && edges_q == EDG_W'(NUM_PER - 1);
    assign expired  = tmo_q == TMO_W'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        edges_d = edges_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        psum_d  = psum_q;
        hsum_d  = hsum_q;
        sat_d   = sat_q;
        tout_d  = tout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = ARM;
                edges_d = '0;
                tmo_d   = '0;
                ovf_d   = 1'b0;
            end
            ARM, MEAS: begin
                tmo_d = rise ? '0 : tmo_q + 1'b1;
                if (state_q == ARM && rise) begin
                    state_d = MEAS;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    edges_d = '0;
                    sat_d   = 1'b0;
                end else if (state_q == MEAS) begin
                    cnt_d  = cnt_inc;
                    hcnt_d = hcnt_inc;
                    sat_d  = sat_q | clip;
                    edges_d = rise ? edges_q + 1'b1 : edges_q;
                end
                // the closing edge takes priority over a coincident timeout
                if (state_q == MEAS && last) begin
                    state_d = DONE;
                    psum_d  = cnt_inc;
                    hsum_d  = hcnt_inc;
                    tout_d  = 1'b0;
                    ovf_d   = sat_q | clip;
                end else if (!rise && expired) begin
                    state_d = DONE;
                    psum_d  = '0;
                    hsum_d  = '0;
                    tout_d  = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            edges_q <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            psum_q  <= '0;
            hsum_q  <= '0;
            sat_q   <= 1'b0;
            tout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            edges_q <= edges_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            psum_q  <= psum_d;
            hsum_q  <= hsum_d;
            sat_q   <= sat_d;
            tout_q  <= tout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy       = state_q == ARM || state_q == MEAS;
    assign bus.done       = state_q == DONE;
    assign bus.period_sum = psum_q;
    assign bus.high_sum   = hsum_q;
    assign bus.timeout    = tout_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of two meters (16-bit and 4-bit accumulators) fed by
// synchronous clock dividers with known period and duty.
module tb_clk_period_meter;
    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_a = 0;
    int   done_b = 0;
    int   hi_a = 0, lo_a = 0, ph_a = 0;
    int   hi_b = 0, lo_b = 0, ph_b = 0;

    clk_period_meter_if #(.CNT_W(16)) m ();
    clk_period_meter_if #(.CNT_W(4))  s ();

    clk_period_meter #(.CNT_W(16), .NUM_PER(4), .SYNC_STAGES(2), .TIMEOUT(64)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );
    clk_period_meter #(.CNT_W(4), .NUM_PER(4), .SYNC_STAGES(2), .TIMEOUT(64)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clock-under-test generators, changing just after each clk posedge
    initial begin
        m.clk_in = 1'b0;
        s.clk_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (lo_a == 0) begin
                m.clk_in = 1'b0;
                ph_a = 0;
            end else begin
                m.clk_in = ph_a < hi_a;
                ph_a = (ph_a + 1 >= hi_a + lo_a) ? 0 : ph_a + 1;
            end
            if (lo_b == 0) begin
                s.clk_in = 1'b0;
                ph_b = 0;
            end else begin
                s.clk_in = ph_b < hi_b;
                ph_b = (ph_b + 1 >= hi_b + lo_b) ? 0 : ph_b + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m.done === 1'b1) done_a++;
            if (s.done === 1'b1) done_b++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) s.start = 1'b1;
        else m.start = 1'b1;
        @(posedge clk);
        #1;
        s.start = 1'b0;
        m.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int limit, output int n, output bit got);
        n = 0;
        while (!(sel ? s.done : m.done) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        got = sel ? s.done : m.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m.start = 1'b0;
        s.start = 1'b0;
        cycles(3);
        vectors++;
        if ({m.busy, m.done, m.timeout, m.ovf} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {m.busy, m.done, m.timeout, m.ovf});
        end
        vectors++;
        if ({m.period_sum, m.high_sum} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_sums: got %0d/%0d want 0/0", m.period_sum, m.high_sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic run_main(input string name, input int hi, input int lo,
                            input int exp_p, input int exp_h);
        int n;
        bit got;
        hi_a = hi;
        lo_a = lo;
        cycles(12);
        done_a = 0;
        pulse_start(1'b0);
        vectors++;
        if (m.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy: got %b want 1", name, m.busy);
        end
        wait_done(1'b0, 200, n, got);
        vectors++;
        if (got !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done: no done within %0d cycles", name, n);
        end
        vectors++;
        if (m.period_sum !== 16'(exp_p) || m.high_sum !== 16'(exp_h)) begin
            miscompares++;
            $display("FAIL %s_sums: got %0d/%0d want %0d/%0d", name, m.period_sum, m.high_sum, exp_p, exp_h);
        end
        vectors++;
        if ({m.timeout, m.ovf} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_flags: got timeout=%b ovf=%b want 0 0", name, m.timeout, m.ovf);
        end
        cycles(4);
        vectors++;
        if (done_a !== 1 || m.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse: got %0d done pulses busy=%b want 1 and 0", name, done_a, m.busy);
        end
    endtask

    task automatic test_even();
        run_main("even", 2, 2, 16, 8);
    endtask

    task automatic test_odd();
        run_main("odd", 3, 2, 20, 12);
    endtask

    task automatic test_stuck();
        int n;
        bit got;
        hi_a = 0;
        lo_a = 0;
        cycles(8);
        pulse_start(1'b0);
        vectors++;
        if (m.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_busy: got %b want 1", m.busy);
        end
        wait_done(1'b0, 200, n, got);
        vectors++;
        if (got !== 1'b1 || n !== 64) begin
            miscompares++;
            $display("FAIL stuck_latency: got done=%b after %0d cycles want 1 after 64", got, n);
        end
        vectors++;
        if (m.timeout !== 1'b1 || m.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_flags: got timeout=%b ovf=%b want 1 0", m.timeout, m.ovf);
        end
        vectors++;
        if (m.period_sum !== 16'd0 || m.high_sum !== 16'd0) begin
            miscompares++;
            $display("FAIL stuck_sums: got %0d/%0d want 0/0", m.period_sum, m.high_sum);
        end
        cycles(2);
    endtask

    task automatic test_overflow();
        int n;
        bit got;
        hi_b = 4;
        lo_b = 4;
        cycles(12);
        pulse_start(1'b1);
        wait_done(1'b1, 200, n, got);
        vectors++;
        if (got !== 1'b1 || s.period_sum !== 4'd15 || s.high_sum !== 4'd15) begin
            miscompares++;
            $display("FAIL ovf_sums: got done=%b %0d/%0d want 1 15/15", got, s.period_sum, s.high_sum);
        end
        vectors++;
        if (s.ovf !== 1'b1 || s.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_flag: got ovf=%b timeout=%b want 1 0", s.ovf, s.timeout);
        end
        hi_b = 1;
        lo_b = 1;
        cycles(8);
        pulse_start(1'b1);
        vectors++;
        if (s.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_on_start: got %b want 0", s.ovf);
        end
        wait_done(1'b1, 200, n, got);
        vectors++;
        if (got !== 1'b1 || s.period_sum !== 4'd8 || s.high_sum !== 4'd4 || s.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_rerun: got done=%b %0d/%0d ovf=%b want 1 8/4 0", got, s.period_sum, s.high_sum, s.ovf);
        end
        cycles(2);
    endtask

    task automatic test_ignored_start();
        int n;
        bit got;
        hi_a = 2;
        lo_a = 2;
        cycles(12);
        done_a = 0;
        pulse_start(1'b0);
        cycles(8);
        pulse_start(1'b0);
        wait_done(1'b0, 200, n, got);
        m.start = 1'b1;
        @(posedge clk);
        #1;
        m.start = 1'b0;
        vectors++;
        if (got !== 1'b1 || m.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_done_start: got done=%b busy=%b want 1 0", got, m.busy);
        end
        cycles(25);
        vectors++;
        if (done_a !== 1 || m.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_pulses: got %0d pulses busy=%b want 1 0", done_a, m.busy);
        end
        vectors++;
        if (m.period_sum !== 16'd16 || m.high_sum !== 16'd8) begin
            miscompares++;
            $display("FAIL ign_sums: got %0d/%0d want 16/8", m.period_sum, m.high_sum);
        end
    endtask

    task automatic test_reset_mid();
        hi_a = 2;
        lo_a = 2;
        cycles(4);
        done_a = 0;
        pulse_start(1'b0);
        cycles(10);
        rst = 1'b1;
        #1;
        vectors++;
        if ({m.busy, m.done, m.timeout, m.ovf} !== 4'b0 || m.period_sum !== 16'd0 || m.high_sum !== 16'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got busy=%b done=%b sums=%0d/%0d want all 0",
                     m.busy, m.done, m.period_sum, m.high_sum);
        end
        cycles(2);
        rst = 1'b0;
        cycles(6);
        vectors++;
        if (done_a !== 0 || m.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_nodone: got %0d pulses busy=%b want 0 0", done_a, m.busy);
        end
        run_main("midrst_rerun", 2, 2, 16, 8);
    endtask

    initial begin
        m.start = 1'b0;
        s.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_even();
        test_odd();
        test_stuck();
        test_overflow();
        test_ignored_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
